// File: rtl/tag_allocator_if.sv
// Request/response bundle between the rename stage and the physical tag free list.
// The allocator side takes the slave modport; the requester side takes master.
interface tag_allocator_if #(
   parameter int SIZE  = 32,
   parameter int WIDTH = 5
);
   logic             i_alloc;
   logic [SIZE-1:0]  o_grant;
   logic             o_valid;
   logic             i_free_en;
   logic [WIDTH-1:0] i_free_tag;
   logic             i_flush;
   logic [WIDTH:0]   o_count;
   logic             o_err;

   modport master (
      output i_alloc, i_free_en, i_free_tag, i_flush,
      input  o_grant, o_valid, o_count, o_err
   );

   modport slave (
      input  i_alloc, i_free_en, i_free_tag, i_flush,
      output o_grant, o_valid, o_count, o_err
   );
endinterface

// File: rtl/tag_allocator.sv
// Physical tag free list: lowest-index free entry is granted one-hot combinationally from state (0-cycle grant, 1-cycle bitmap/count update).
// No backpressure; an alloc is accepted only while o_valid is high, and illegal frees are dropped with a one-cycle o_err pulse.
module tag_allocator #(
   parameter int SIZE  = 32,
   parameter int WIDTH = 5,
   parameter int RSVD0 = 1
) (
   input logic           i_clk,
   input logic           i_rst,
   tag_allocator_if.slave bus
);
   localparam int PAD = 1 << WIDTH;
   localparam logic [SIZE-1:0] FREE_INIT  = {{(SIZE-1){1'b1}}, (RSVD0 == 0)};
   localparam logic [WIDTH:0]  COUNT_INIT = (WIDTH+1)'(SIZE - RSVD0);
   localparam logic [WIDTH:0]  SIZE_W     = (WIDTH+1)'(SIZE);

   logic [SIZE-1:0] free_q, free_d;
   logic [WIDTH:0]  count_q, count_d;
   logic            err_q, err_d;

   logic [SIZE-1:0] grant;
   logic [PAD-1:0]  free_pad;
   logic [PAD-1:0]  set_pad;
   logic [SIZE-1:0] free_set;
   logic            in_range;
   logic            is_rsvd;
   logic            tag_is_free;
   logic            alloc_ok;
   logic            free_ok;

   // Two's-complement trick isolates the lowest set bit.
   assign grant = free_q & (~free_q + SIZE'(1));

   // Padding the bitmap to 2^WIDTH keeps out-of-range tags indexable.
   assign free_pad    = PAD'(free_q);
   assign set_pad     = PAD'(1) << bus.i_free_tag;
   assign free_set    = SIZE'(set_pad);
   assign in_range    = {1'b0, bus.i_free_tag} < SIZE_W;
   assign is_rsvd     = (RSVD0 != 0) && (bus.i_free_tag == '0);
   assign tag_is_free = free_pad[bus.i_free_tag];

   assign alloc_ok = bus.i_alloc && (|free_q);
   assign free_ok  = bus.i_free_en && in_range && !is_rsvd && !tag_is_free;

   always_comb begin
      free_d  = free_q;
      count_d = count_q;
      err_d   = 1'b0;
      if (bus.i_flush) begin
         free_d  = FREE_INIT;
         count_d = COUNT_INIT;
      end else begin
         if (alloc_ok) free_d = free_d & ~grant;
         if (free_ok)  free_d = free_d | free_set;
         err_d = bus.i_free_en && !free_ok;
         case ({alloc_ok, free_ok})
            2'b10:   count_d = count_q - (WIDTH+1)'(1);
            2'b01:   count_d = count_q + (WIDTH+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         free_q  <= FREE_INIT;
         count_q <= COUNT_INIT;
         err_q   <= 1'b0;
      end else begin
         free_q  <= free_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign bus.o_grant = grant;
   assign bus.o_valid = |free_q;
   assign bus.o_count = count_q;
   assign bus.o_err   = err_q;
endmodule

// File: tb/tb_tag_allocator.sv
// Directed plus random stimulus against a free-set reference model for tag_allocator.
module tb_tag_allocator;
   localparam int SIZE  = 32;
   localparam int WIDTH = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   bit free_m [SIZE];
   bit err_m;

   tag_allocator_if #(.SIZE(SIZE), .WIDTH(WIDTH)) bus ();

   tag_allocator #(.SIZE(SIZE), .WIDTH(WIDTH), .RSVD0(1)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   function automatic void model_init();
      for (int i = 0; i < SIZE; i++) free_m[i] = (i != 0);
      err_m = 1'b0;
   endfunction

   function automatic int lowest_free();
      for (int i = 0; i < SIZE; i++) if (free_m[i]) return i;
      return -1;
   endfunction

   function automatic int free_count();
      int n = 0;
      for (int i = 0; i < SIZE; i++) n += int'(free_m[i]);
      return n;
   endfunction

   function automatic logic [SIZE-1:0] model_grant();
      logic [SIZE-1:0] g = '0;
      int idx = lowest_free();
      if (idx >= 0) g[idx] = 1'b1;
      return g;
   endfunction

   // Downstream one-hot to binary encoder.
   function automatic int encode(input logic [SIZE-1:0] oh);
      int q = 0;
      for (int i = 0; i < SIZE; i++) if (oh[i]) q = i;
      return q;
   endfunction

   task automatic check_model();
      chk("grant", 64'(bus.o_grant), 64'(model_grant()));
      chk("valid", 64'(bus.o_valid), 64'(lowest_free() >= 0));
      chk("count", 64'(bus.o_count), 64'(free_count()));
      chk("err",   64'(bus.o_err),   64'(err_m));
      if (lowest_free() >= 0)
         chk("enc_q", 64'(encode(bus.o_grant)), 64'(lowest_free()));
   endtask

   function automatic void model_step(input bit a, input bit fe, input int t, input bit fl, input bit r);
      int  g = lowest_free();
      bit  legal;
      if (r || fl) begin
         model_init();
         return;
      end
      legal = fe && (t < SIZE) && (t != 0) && !free_m[t];
      if (a && g >= 0) free_m[g] = 1'b0;
      if (legal) free_m[t] = 1'b1;
      err_m = fe && !legal;
   endfunction

   task automatic cycle(input bit a, input bit fe, input int t, input bit fl, input bit r);
      bus.i_alloc    = a;
      bus.i_free_en  = fe;
      bus.i_free_tag = WIDTH'(t);
      bus.i_flush    = fl;
      rst            = r;
      #1;
      check_model();
      model_step(a, fe, t, fl, r);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.i_alloc    = 1'b0;
      bus.i_free_en  = 1'b0;
      bus.i_free_tag = '0;
      bus.i_flush    = 1'b0;
      rst            = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_init();

      // Reset state.
      #1;
      chk("rst_grant", 64'(bus.o_grant), 64'h2);
      chk("rst_valid", 64'(bus.o_valid), 64'h1);
      chk("rst_count", 64'(bus.o_count), 64'd31);
      chk("rst_err",   64'(bus.o_err),   64'h0);
      chk("rst_enc",   64'(encode(bus.o_grant)), 64'd1);

      // Three back-to-back allocs.
      cycle(1, 0, 0, 0, 0);
      chk("a1_grant", 64'(bus.o_grant), 64'h4);
      cycle(1, 0, 0, 0, 0);
      chk("a2_grant", 64'(bus.o_grant), 64'h8);
      cycle(1, 0, 0, 0, 0);
      chk("a3_count", 64'(bus.o_count), 64'd28);

      // Drain the pool; an alloc while empty is ignored.
      for (int i = 0; i < 40 && lowest_free() >= 0; i++) cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      chk("empty_valid", 64'(bus.o_valid), 64'h0);
      chk("empty_grant", 64'(bus.o_grant), 64'h0);
      chk("empty_count", 64'(bus.o_count), 64'd0);
      cycle(0, 1, 7, 0, 0);
      chk("refill_grant", 64'(bus.o_grant), 64'h80);
      chk("refill_count", 64'(bus.o_count), 64'd1);

      // Simultaneous alloc and legal free.
      cycle(0, 0, 0, 0, 1);
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(1, 1, 1, 0, 0);
      chk("af_count", 64'(bus.o_count), 64'd29);
      chk("af_grant", 64'(bus.o_grant), 64'h2);

      // Illegal frees: reserved, double, and granted tag under alloc.
      cycle(0, 1, 0, 0, 0);
      chk("rsvd_err", 64'(bus.o_err), 64'h1);
      cycle(0, 0, 0, 0, 0);
      chk("err_clear", 64'(bus.o_err), 64'h0);
      cycle(0, 1, 5, 0, 0);
      chk("dbl_err", 64'(bus.o_err), 64'h1);
      chk("dbl_count", 64'(bus.o_count), 64'd29);
      cycle(1, 1, 1, 0, 0);
      chk("gnt_err",   64'(bus.o_err),   64'h1);
      chk("gnt_count", 64'(bus.o_count), 64'd28);
      chk("gnt_grant", 64'(bus.o_grant), 64'h10);

      // Flush beats same-cycle alloc/free; reset beats alloc.
      cycle(0, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 0);
      cycle(1, 1, 4, 1, 0);
      chk("fl_count", 64'(bus.o_count), 64'd31);
      chk("fl_grant", 64'(bus.o_grant), 64'h2);
      chk("fl_err",   64'(bus.o_err),   64'h0);
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 1);
      chk("rs_count", 64'(bus.o_count), 64'd31);
      chk("rs_grant", 64'(bus.o_grant), 64'h2);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 99) < 55),
               ($urandom_range(0, 99) < 45),
               int'($urandom_range(0, SIZE - 1)),
               ($urandom_range(0, 199) == 0),
               ($urandom_range(0, 399) == 0));
      end
      check_model();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
